// File: rtl/byte_striping_ctrl.sv
// Lane scheduler for the 4-lane byte-striping datapath.
// Accepts bytes over inVLD/inRDY and spreads them round-robin over 1, 2 or 4
// lanes with registered one-hot write strobes. A stripe that stalls part-way
// is closed with PAD_BYTE after PAD_TIMEOUT idle cycles.
module byte_striping_ctrl #(
   parameter logic [7:0] PAD_BYTE    = 8'hF7,
   parameter int         PAD_TIMEOUT = 4
) (
   input  logic       clk1Mhz,
   input  logic       reset,
   input  logic       enb,
   input  logic [1:0] laneMode,
   input  logic       inVLD,
   input  logic [7:0] inData,
   output logic       inRDY,
   output logic [3:0] laneWE,
   output logic [1:0] laneSel,
   output logic [7:0] laneData,
   output logic       stripeVLD,
   output logic       padActive,
   output logic [7:0] stripeCnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PAD  = 2'd2
   } state_t;

   localparam logic [3:0] PAD_TO_C = 4'(PAD_TIMEOUT);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [1:0] ptr_r;
   logic [1:0] ptr_nxt_s;
   logic [3:0] idle_cnt_r;
   logic [3:0] idle_nxt_s;
   logic [1:0] mode_r;
   logic [1:0] mode_eff_s;
   logic [1:0] last_idx_s;
   logic       xfer_s;
   logic       wr_s;
   logic       done_s;
   logic [7:0] wr_data_s;

   // One-hot strobe for a lane index.
   function automatic logic [3:0] one_hot(input logic [1:0] idx);
      logic [3:0] oh;
      case (idx)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Index of the last lane of a stripe for a given mode; 11 behaves as x4.
   function automatic logic [1:0] last_lane(input logic [1:0] mode);
      logic [1:0] li;
      case (mode)
         2'b00:   li = 2'd0;
         2'b01:   li = 2'd1;
         default: li = 2'd3;
      endcase
      return li;
   endfunction

   // In IDLE the mode register tracks laneMode, so the live value is the one
   // that will be latched when the first byte of a stripe is accepted.
   assign mode_eff_s = (state_r == IDLE) ? laneMode : mode_r;
   assign last_idx_s = last_lane(mode_eff_s);

   assign inRDY  = enb & ~reset & ((state_r == IDLE) | (state_r == FILL));
   assign xfer_s = inVLD & inRDY;

   // Next-state, pointer, idle counter and write request.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      idle_nxt_s  = idle_cnt_r;
      wr_s        = 1'b0;
      done_s      = 1'b0;
      wr_data_s   = inData;
      if (enb) begin
         case (state_r)
            IDLE: begin
               idle_nxt_s = 4'd0;
               if (xfer_s) begin
                  wr_s = 1'b1;
                  if (last_idx_s == 2'd0) begin
                     done_s    = 1'b1;
                     ptr_nxt_s = 2'd0;
                  end else begin
                     ptr_nxt_s   = 2'd1;
                     state_nxt_s = FILL;
                  end
               end else begin
                  ptr_nxt_s = 2'd0;
               end
            end
            FILL: begin
               if (xfer_s) begin
                  wr_s       = 1'b1;
                  idle_nxt_s = 4'd0;
                  if (ptr_r == last_idx_s) begin
                     done_s      = 1'b1;
                     ptr_nxt_s   = 2'd0;
                     state_nxt_s = IDLE;
                  end else begin
                     ptr_nxt_s = ptr_r + 2'd1;
                  end
               end else if ((idle_cnt_r + 4'd1) == PAD_TO_C) begin
                  idle_nxt_s  = 4'd0;
                  state_nxt_s = PAD;
               end else begin
                  idle_nxt_s = idle_cnt_r + 4'd1;
               end
            end
            PAD: begin
               wr_s      = 1'b1;
               wr_data_s = PAD_BYTE;
               if (ptr_r == last_idx_s) begin
                  done_s      = 1'b1;
                  ptr_nxt_s   = 2'd0;
                  state_nxt_s = IDLE;
               end else begin
                  ptr_nxt_s = ptr_r + 2'd1;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               ptr_nxt_s   = 2'd0;
               idle_nxt_s  = 4'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Control state: FSM state, lane pointer, idle counter and latched mode.
   always_ff @(posedge clk1Mhz) begin
      if (reset) begin
         state_r    <= IDLE;
         ptr_r      <= 2'd0;
         idle_cnt_r <= 4'd0;
         mode_r     <= 2'b10;
      end else begin
         state_r    <= state_nxt_s;
         ptr_r      <= ptr_nxt_s;
         idle_cnt_r <= idle_nxt_s;
         if (enb && (state_r == IDLE)) begin
            mode_r <= laneMode;
         end
      end
   end

   // Registered lane write port; select and data hold between writes.
   always_ff @(posedge clk1Mhz) begin
      if (reset) begin
         laneWE   <= 4'd0;
         laneSel  <= 2'd0;
         laneData <= 8'd0;
      end else begin
         laneWE <= wr_s ? one_hot(ptr_r) : 4'd0;
         if (wr_s) begin
            laneSel  <= ptr_r;
            laneData <= wr_data_s;
         end
      end
   end

   // Stripe completion pulse, completed-stripe counter and pad indicator.
   always_ff @(posedge clk1Mhz) begin
      if (reset) begin
         stripeVLD <= 1'b0;
         stripeCnt <= 8'd0;
         padActive <= 1'b0;
      end else begin
         stripeVLD <= done_s;
         padActive <= (state_r == PAD);
         if (done_s) begin
            stripeCnt <= stripeCnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_byte_striping_ctrl.sv
// Directed self-checking bench for byte_striping_ctrl.
`timescale 1ns/1ps
module tb_byte_striping_ctrl;

   logic       clk1Mhz = 1'b0;
   logic       reset;
   logic       enb;
   logic [1:0] laneMode;
   logic       inVLD;
   logic [7:0] inData;
   logic       inRDY;
   logic [3:0] laneWE;
   logic [1:0] laneSel;
   logic [7:0] laneData;
   logic       stripeVLD;
   logic       padActive;
   logic [7:0] stripeCnt;

   int errors = 0;
   int checks = 0;

   byte_striping_ctrl #(.PAD_BYTE(8'hF7), .PAD_TIMEOUT(4)) dut (
      .clk1Mhz  (clk1Mhz),
      .reset    (reset),
      .enb      (enb),
      .laneMode (laneMode),
      .inVLD    (inVLD),
      .inData   (inData),
      .inRDY    (inRDY),
      .laneWE   (laneWE),
      .laneSel  (laneSel),
      .laneData (laneData),
      .stripeVLD(stripeVLD),
      .padActive(padActive),
      .stripeCnt(stripeCnt)
   );

   always #500 clk1Mhz = ~clk1Mhz;

   task automatic tick();
      @(posedge clk1Mhz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte, clock it, and check the registered lane write.
   task automatic xfer(input string tag, input logic [7:0] d, input logic [3:0] exp_we,
                       input logic [1:0] exp_sel, input logic exp_vld, input logic [7:0] exp_cnt);
      inVLD  = 1'b1;
      inData = d;
      #1;
      chk({tag, ".rdy"}, 32'(inRDY), 32'd1);
      tick();
      chk({tag, ".we"},   32'(laneWE),    32'(exp_we));
      chk({tag, ".sel"},  32'(laneSel),   32'(exp_sel));
      chk({tag, ".data"}, 32'(laneData),  32'(d));
      chk({tag, ".vld"},  32'(stripeVLD), 32'(exp_vld));
      chk({tag, ".cnt"},  32'(stripeCnt), 32'(exp_cnt));
      inVLD = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      enb      = 1'b1;
      laneMode = 2'b10;
      inVLD    = 1'b0;
      inData   = 8'h00;

      // Reset state
      tick();
      tick();
      chk("rst.rdy",  32'(inRDY),     32'd0);
      chk("rst.we",   32'(laneWE),    32'd0);
      chk("rst.sel",  32'(laneSel),   32'd0);
      chk("rst.data", 32'(laneData),  32'd0);
      chk("rst.vld",  32'(stripeVLD), 32'd0);
      chk("rst.pad",  32'(padActive), 32'd0);
      chk("rst.cnt",  32'(stripeCnt), 32'd0);
      reset = 1'b0;
      #1;
      chk("idle.rdy", 32'(inRDY), 32'd1);
      tick();

      // x4 streaming
      xfer("x4a", 8'h01, 4'b0001, 2'd0, 1'b0, 8'd0);
      xfer("x4b", 8'h02, 4'b0010, 2'd1, 1'b0, 8'd0);
      xfer("x4c", 8'h03, 4'b0100, 2'd2, 1'b0, 8'd0);
      xfer("x4d", 8'h04, 4'b1000, 2'd3, 1'b1, 8'd1);
      tick();
      chk("x4.we0",   32'(laneWE),    32'd0);
      chk("x4.vld0",  32'(stripeVLD), 32'd0);
      chk("x4.hold",  32'(laneData),  32'h04);

      // x2 then x1; mode change in FILL only applies after the stripe closes
      laneMode = 2'b01;
      tick();
      xfer("x2a", 8'hAA, 4'b0001, 2'd0, 1'b0, 8'd1);
      xfer("x2b", 8'hBB, 4'b0010, 2'd1, 1'b1, 8'd2);
      xfer("x2c", 8'hCC, 4'b0001, 2'd0, 1'b0, 8'd2);
      laneMode = 2'b00;
      xfer("x2d", 8'hDD, 4'b0010, 2'd1, 1'b1, 8'd3);
      tick();
      xfer("x1a", 8'hEE, 4'b0001, 2'd0, 1'b1, 8'd4);
      xfer("x1b", 8'h5A, 4'b0001, 2'd0, 1'b1, 8'd5);

      // Padding after 4 idle cycles in FILL
      laneMode = 2'b10;
      tick();
      xfer("pada", 8'h11, 4'b0001, 2'd0, 1'b0, 8'd5);
      xfer("padb", 8'h22, 4'b0010, 2'd1, 1'b0, 8'd5);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("pad.wait.we",  32'(laneWE),    32'd0);
         chk("pad.wait.pa",  32'(padActive), 32'd0);
      end
      chk("pad.rdy", 32'(inRDY), 32'd0);
      tick();
      chk("pad2.we",   32'(laneWE),    32'b0100);
      chk("pad2.data", 32'(laneData),  32'hF7);
      chk("pad2.pa",   32'(padActive), 32'd1);
      chk("pad2.vld",  32'(stripeVLD), 32'd0);
      chk("pad2.rdy",  32'(inRDY),     32'd0);
      tick();
      chk("pad3.we",   32'(laneWE),    32'b1000);
      chk("pad3.data", 32'(laneData),  32'hF7);
      chk("pad3.pa",   32'(padActive), 32'd1);
      chk("pad3.vld",  32'(stripeVLD), 32'd1);
      chk("pad3.cnt",  32'(stripeCnt), 32'd6);
      tick();
      chk("padx.pa",   32'(padActive), 32'd0);
      chk("padx.we",   32'(laneWE),    32'd0);
      chk("padx.rdy",  32'(inRDY),     32'd1);

      // enb freeze with inVLD held high
      xfer("enba", 8'h31, 4'b0001, 2'd0, 1'b0, 8'd6);
      xfer("enbb", 8'h32, 4'b0010, 2'd1, 1'b0, 8'd6);
      enb    = 1'b0;
      inVLD  = 1'b1;
      inData = 8'h99;
      #1;
      chk("enb.rdy", 32'(inRDY), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("enb.we",  32'(laneWE),    32'd0);
         chk("enb.vld", 32'(stripeVLD), 32'd0);
         chk("enb.pa",  32'(padActive), 32'd0);
      end
      chk("enb.cnt", 32'(stripeCnt), 32'd6);
      enb = 1'b1;
      xfer("enbc", 8'h33, 4'b0100, 2'd2, 1'b0, 8'd6);
      xfer("enbd", 8'h34, 4'b1000, 2'd3, 1'b1, 8'd7);

      // Reset mid-stripe
      xfer("rsta", 8'h41, 4'b0001, 2'd0, 1'b0, 8'd7);
      xfer("rstb", 8'h42, 4'b0010, 2'd1, 1'b0, 8'd7);
      xfer("rstc", 8'h43, 4'b0100, 2'd2, 1'b0, 8'd7);
      reset = 1'b1;
      #1;
      chk("mrst.rdy", 32'(inRDY), 32'd0);
      tick();
      chk("mrst.we",   32'(laneWE),    32'd0);
      chk("mrst.data", 32'(laneData),  32'd0);
      chk("mrst.vld",  32'(stripeVLD), 32'd0);
      chk("mrst.cnt",  32'(stripeCnt), 32'd0);
      reset = 1'b0;
      xfer("post0", 8'h44, 4'b0001, 2'd0, 1'b0, 8'd0);
      xfer("post1", 8'h45, 4'b0010, 2'd1, 1'b0, 8'd0);
      xfer("post2", 8'h46, 4'b0100, 2'd2, 1'b0, 8'd0);
      xfer("post3", 8'h47, 4'b1000, 2'd3, 1'b1, 8'd1);

      // stripeCnt wrap with x1 stripes
      laneMode = 2'b00;
      tick();
      for (int k = 1; k <= 255; k++) begin
         xfer("wrap", 8'(k), 4'b0001, 2'd0, 1'b1, 8'(k + 1));
      end
      chk("wrap.zero", 32'(stripeCnt), 32'd0);
      xfer("wrap1", 8'hC3, 4'b0001, 2'd0, 1'b1, 8'd1);

      // Mode latched for the stripe in progress
      laneMode = 2'b10;
      tick();
      xfer("lat0", 8'h61, 4'b0001, 2'd0, 1'b0, 8'd1);
      laneMode = 2'b01;
      xfer("lat1", 8'h62, 4'b0010, 2'd1, 1'b0, 8'd1);
      xfer("lat2", 8'h63, 4'b0100, 2'd2, 1'b0, 8'd1);
      xfer("lat3", 8'h64, 4'b1000, 2'd3, 1'b1, 8'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
